// File: rtl/read_line_assembler.sv
// read_line_assembler: gathers refill beats into a line buffer and writes the whole line to the data memory.
// Optional critical-word forwarding is enabled by defining READ_LINE_ASM_CWF_EN.
module read_line_assembler #(
  parameter int FE_DATA_W = 32,
  parameter int BE_DATA_W = 32,
  parameter int WORD_OFF_W = 3,
  localparam int LINE2MEM_W = WORD_OFF_W - $clog2(BE_DATA_W / FE_DATA_W),
  localparam int LINE_W = FE_DATA_W * (2 ** WORD_OFF_W),
  localparam int AW = (LINE2MEM_W > 0) ? LINE2MEM_W : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  replace,
  input  logic                  read_valid,
  input  logic [AW-1:0]         read_addr,
  input  logic [BE_DATA_W-1:0]  read_rdata,
  output logic                  line_we,
  output logic [LINE_W-1:0]     line_wdata,
  input  logic                  line_ready,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  fill_err,
  output logic                  overrun
`ifdef READ_LINE_ASM_CWF_EN
  ,
  input  logic [WORD_OFF_W-1:0] req_word_off,
  output logic                  fwd_valid,
  output logic [FE_DATA_W-1:0]  fwd_rdata
`endif
);
  localparam int N = 2 ** LINE2MEM_W;
  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [N-1:0] mask_q, mask_d, mask_nx;
  logic [LINE_W-1:0] line_q, line_d;
  logic err_q, err_d, overrun_q, overrun_d;
  logic [AW-1:0] slot;
  always_comb begin
    slot = (LINE2MEM_W == 0) ? '0 : read_addr;
    mask_nx = mask_q | (read_valid ? N'(1) << slot : '0);
    state_d = state_q;
    mask_d = mask_q;
    line_d = line_q;
    err_d = 1'b0;
    overrun_d = overrun_q | (read_valid && state_q != FILL);
    unique case (state_q)
      IDLE: if (replace) begin
        state_d = FILL;
        mask_d = '0;
      end
      FILL: begin
        // a beat arriving with the falling replace still counts toward completeness
        mask_d = mask_nx;
        if (read_valid) line_d[slot * BE_DATA_W +: BE_DATA_W] = read_rdata;
        if (!replace) begin
          state_d = (&mask_nx) ? WRITE : IDLE;
          err_d = ~&mask_nx;
        end
      end
      WRITE: state_d = line_ready ? DONE : WRITE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q <= '0;
      line_q <= '0;
      err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      line_q <= line_d;
      err_q <= err_d;
      overrun_q <= overrun_d;
    end
  end
  assign line_we = state_q == WRITE;
  assign line_wdata = line_q;
  assign fill_busy = state_q != IDLE;
  assign fill_done = state_q == DONE;
  assign fill_err = err_q;
  assign overrun = overrun_q;
`ifdef READ_LINE_ASM_CWF_EN
  localparam int R = BE_DATA_W / FE_DATA_W;
  localparam int RB = $clog2(R);
  logic [WORD_OFF_W-1:0] req_q, req_d;
  logic sent_q, sent_d, fwd_valid_q, fwd_valid_d, start, hit;
  logic [FE_DATA_W-1:0] fwd_q, fwd_d;
  always_comb begin
    start = state_q == IDLE && replace;
    req_d = start ? req_word_off : req_q;
    // sent_q keeps a retried burst from forwarding the same word twice
    hit = state_q == FILL && read_valid && !sent_q && slot == AW'(req_q >> RB);
    sent_d = start ? 1'b0 : sent_q | hit;
    fwd_valid_d = hit;
    fwd_d = start ? '0 : hit ? read_rdata[(int'(req_q) % R) * FE_DATA_W +: FE_DATA_W] : fwd_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= '0;
      sent_q <= 1'b0;
      fwd_valid_q <= 1'b0;
      fwd_q <= '0;
    end else begin
      req_q <= req_d;
      sent_q <= sent_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_q <= fwd_d;
    end
  end
  assign fwd_valid = fwd_valid_q;
  assign fwd_rdata = fwd_q;
`endif
endmodule

// File: tb/tb_read_line_assembler.sv
// tb_read_line_assembler: directed plus randomized refills checked against a slot-array model of the line.
module tb_read_line_assembler;
  localparam int LINE_W = 256;
  logic clk = 1'b0, reset = 1'b1, replace = 1'b0, read_valid = 1'b0, line_ready = 1'b0;
  logic [2:0] read_addr = '0;
  logic [31:0] read_rdata = '0;
  logic line_we, fill_busy, fill_done, fill_err, overrun;
  logic [LINE_W-1:0] line_wdata;
`ifdef READ_LINE_ASM_CWF_EN
  logic [2:0] req_word_off = '0;
  logic fwd_valid;
  logic [31:0] fwd_rdata;
`endif
  int cnt = 0, errs = 0;
  logic [31:0] mdl [8];
  bit seen [8];
  logic [2:0] qa [$];
  logic [31:0] qd [$];

  read_line_assembler dut (
    .clk(clk), .reset(reset), .replace(replace), .read_valid(read_valid),
    .read_addr(read_addr), .read_rdata(read_rdata), .line_we(line_we),
    .line_wdata(line_wdata), .line_ready(line_ready), .fill_busy(fill_busy),
    .fill_done(fill_done), .fill_err(fill_err), .overrun(overrun)
`ifdef READ_LINE_ASM_CWF_EN
    , .req_word_off(req_word_off), .fwd_valid(fwd_valid), .fwd_rdata(fwd_rdata)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    cnt++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] exp_line();
    logic [LINE_W-1:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = mdl[k];
    return l;
  endfunction

  task automatic push(input logic [2:0] a, input logic [31:0] d);
    qa.push_back(a);
    qd.push_back(d);
  endtask

  // plays queued beats inside one replace window, then checks the completion decision
  task automatic play(input bit join_last, output bit complete);
    int nb = qa.size();
    foreach (seen[i]) seen[i] = 1'b0;
    replace = 1'b1;
    tick();
    for (int i = 0; i < nb; i++) begin
      read_valid = 1'b1;
      read_addr = qa[i];
      read_rdata = qd[i];
      mdl[qa[i]] = qd[i];
      seen[qa[i]] = 1'b1;
      if (join_last && i == nb - 1) replace = 1'b0;
      tick();
      read_valid = 1'b0;
      if (i < nb - 1 && $urandom_range(0, 3) == 0) tick();
    end
    if (!(join_last && nb > 0)) begin
      replace = 1'b0;
      tick();
    end
    complete = 1'b1;
    foreach (seen[i]) complete &= seen[i];
    if (complete) begin
      chk("write_we", LINE_W'(line_we), 1);
      chk("write_data", line_wdata, exp_line());
      chk("write_busy", LINE_W'(fill_busy), 1);
      chk("write_noerr", LINE_W'(fill_err), 0);
    end else begin
      chk("err_pulse", LINE_W'(fill_err), 1);
      chk("err_no_we", LINE_W'(line_we), 0);
      chk("err_idle", LINE_W'(fill_busy), 0);
      tick();
      chk("err_clear", LINE_W'(fill_err), 0);
      chk("err_no_we2", LINE_W'(line_we), 0);
    end
    qa.delete();
    qd.delete();
  endtask

  task automatic finish_write(input int stall);
    for (int s = 0; s < stall; s++) begin
      line_ready = 1'b0;
      tick();
      chk("stall_we", LINE_W'(line_we), 1);
      chk("stall_data", line_wdata, exp_line());
    end
    line_ready = 1'b1;
    tick();
    chk("done_pulse", LINE_W'(fill_done), 1);
    chk("done_no_we", LINE_W'(line_we), 0);
    line_ready = 1'b0;
    tick();
    chk("done_clear", LINE_W'(fill_done), 0);
    chk("done_idle", LINE_W'(fill_busy), 0);
  endtask

  initial begin
    bit c;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_we", LINE_W'(line_we), 0);
    chk("rst_busy", LINE_W'(fill_busy), 0);
    chk("rst_done", LINE_W'(fill_done), 0);
    chk("rst_err", LINE_W'(fill_err), 0);
    chk("rst_ovr", LINE_W'(overrun), 0);
    chk("rst_data", line_wdata, '0);

    line_ready = 1'b1;
    for (int k = 0; k < 8; k++) push(3'(k), 32'h11111111 * k);
    play(1'b0, c);
    finish_write(0);

    for (int k = 0; k < 8; k++) push(3'(k), 32'h00000BAD);
    for (int k = 0; k < 8; k++) push(3'(k), 32'hC0DE0000 + k);
    play(1'b0, c);
    finish_write(0);

    for (int k = 0; k < 5; k++) push(3'(k), $urandom);
    play(1'b0, c);
    chk("incomplete_flag", LINE_W'(c), 0);

    for (int k = 0; k < 8; k++) push(3'(k), $urandom);
    play(1'b0, c);
    finish_write(6);

    replace = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      read_valid = 1'b1;
      read_addr = 3'(k);
      read_rdata = $urandom | 32'h1;
      tick();
    end
    read_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    replace = 1'b0;
    chk("mrst_we", LINE_W'(line_we), 0);
    chk("mrst_busy", LINE_W'(fill_busy), 0);
    chk("mrst_err", LINE_W'(fill_err), 0);
    chk("mrst_data", line_wdata, '0);
    tick();
    chk("mrst_no_we", LINE_W'(line_we), 0);
    for (int k = 7; k >= 0; k--) push(3'(k), $urandom);
    play(1'b1, c);
    chk("ovr_clean", LINE_W'(overrun), 0);
    line_ready = 1'b1;
    tick();
    line_ready = 1'b0;
    chk("ovr_in_done", LINE_W'(fill_done), 1);
    read_valid = 1'b1;
    read_addr = 3'd2;
    read_rdata = ~mdl[2];
    tick();
    read_valid = 1'b0;
    chk("ovr_set", LINE_W'(overrun), 1);
    chk("ovr_data_kept", line_wdata, exp_line());

    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        int s = $urandom_range(0, 7);
        for (int k = 0; k < 8; k++) push(3'((s + k) % 8), $urandom);
        for (int k = $urandom_range(0, 3); k > 0; k--) push(3'($urandom_range(0, 7)), $urandom);
      end else begin
        for (int k = $urandom_range(1, 12); k > 0; k--) push(3'($urandom_range(0, 7)), $urandom);
      end
      play(1'($urandom_range(0, 1)), c);
      if (c) finish_write($urandom_range(0, 3));
    end
    chk("ovr_sticky", LINE_W'(overrun), 1);

`ifdef READ_LINE_ASM_CWF_EN
    req_word_off = 3'd5;
    replace = 1'b1;
    tick();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 8; k++) begin
        read_valid = 1'b1;
        read_addr = 3'(k);
        read_rdata = 32'hF0000000 + 32'(r * 16 + k);
        mdl[k] = read_rdata;
        tick();
        chk("fwd_valid", LINE_W'(fwd_valid), LINE_W'(r == 0 && k == 5));
      end
    end
    chk("fwd_rdata", LINE_W'(fwd_rdata), LINE_W'(32'hF0000005));
    read_valid = 1'b0;
    replace = 1'b0;
    tick();
    chk("fwd_write", line_wdata, exp_line());
    finish_write(0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, errs);
    $finish;
  end
endmodule

// File: doc/read_line_assembler.md
Name: read_line_assembler

Overview:
Sits directly downstream of the AXI read channel in the cache refill path. It captures the back-end beats (read_valid/read_addr/read_rdata) into a full-line buffer while replace is high. When the refill completes, it writes the whole line into the cache data memory in one transfer. It also reports completion, refill errors and protocol overruns to the cache controller.

Parameters:
FE_DATA_W  32  front-end word width
BE_DATA_W  32  back-end beat width; a multiple of FE_DATA_W
WORD_OFF_W  3  log2 of FE words per line
LINE2MEM_W  WORD_OFF_W-$clog2(BE_DATA_W/FE_DATA_W)  log2 of beats per line; derived, not overridden
LINE_W  FE_DATA_W*2**WORD_OFF_W  line width in bits; derived

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
replace  in  1  high while the read channel owns a refill (including error retries)
read_valid  in  1  beat valid
read_addr  in  max(LINE2MEM_W,1)  beat index within the line
read_rdata  in  BE_DATA_W  beat data
line_we  out  1  line write request to the data memory
line_wdata  out  LINE_W  assembled line; beat k occupies bits [k*BE_DATA_W +: BE_DATA_W]
line_ready  in  1  data memory accepts the line this cycle
fill_busy  out  1  buffer occupied; the controller must not raise replace_valid while it is high
fill_done  out  1  one-cycle pulse after the line is accepted
fill_err  out  1  one-cycle pulse when a refill ends with missing beats
overrun  out  1  sticky flag: beat arrived while not in FILL; cleared only by reset

Behaviour:
- Decided: one clock, clk; reset is synchronous and active-high, port name reset.
- N = 2**LINE2MEM_W beats per line. If LINE2MEM_W == 0: N = 1 and read_addr is ignored (slot 0).
- State: valid mask of N bits, plus line buffer registers.
- Reset values: state IDLE, mask 0, buffer 0, line_we 0, fill_busy 0, fill_done 0, fill_err 0, overrun 0.
- Reset asserted mid-operation discards the partial line. No line_we is issued afterwards.

State machine: IDLE, FILL, WRITE, DONE.
- IDLE
  - replace==1 -> FILL; mask cleared.
  - fill_busy = 0.
- FILL
  - Each read_valid: buffer[read_addr] <= read_rdata; mask[read_addr] <= 1.
  - Repeated index, e.g. a burst retried after a slave error, overwrites the slot; the last write wins.
  - replace 1->0 with mask all ones -> WRITE.
  - replace 1->0 with mask incomplete -> IDLE; fill_err pulses for 1 cycle; no line_we.
  - A read_valid in the same cycle replace is sampled low is still captured before the completeness check.
- WRITE
  - line_we = 1 and line_wdata stable until the cycle line_ready == 1 -> DONE.
  - line_ready may be held high in advance; minimum WRITE residency is 1 cycle.
- DONE
  - fill_done = 1 for exactly one cycle -> IDLE.
- fill_busy = 1 in FILL, WRITE and DONE.
- Latency with line_ready tied high: last beat at cycle t; replace low at t+1; line_we at t+2; fill_done at t+3.
- read_valid in IDLE/WRITE/DONE: data ignored and overrun set.
- replace rising while in WRITE/DONE: ignored until IDLE. The next entry to FILL then happens on the first IDLE cycle that sees replace high.
- line_wdata is driven straight from the buffer registers; no combinational path from the inputs.

Optional Feature:
- Macro: READ_LINE_ASM_CWF_EN (critical-word forwarding).
- Defined: adds inputs req_word_off [WORD_OFF_W-1:0] (sampled on the IDLE->FILL transition) and outputs fwd_valid (1) and fwd_rdata (FE_DATA_W).
  - fwd_valid pulses for 1 cycle, registered, the cycle after the beat containing the requested FE word is first captured.
  - fwd_rdata holds that FE word until the next fill starts.
  - A retry does not re-pulse fwd_valid.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- Defaults (N=8): replace high, 8 beats, addr 0..7, data 0x11111111*k, replace low -> line_we with line_wdata[k*32+:32] == 0x11111111*k; fill_done 1 cycle after line_ready.
- Retry: 8 beats of 0xBAD, replace held, addr reset to 0, 8 beats of 0xC0DE0000+k, replace low -> line holds only 0xC0DE0000+k values; fill_err stays 0.
- Incomplete: 5 beats (addr 0..4), replace low -> fill_err pulse; line_we never asserts; fill_busy 0 next cycle.
- Backpressure: line_ready low 6 cycles after line_we -> line_we and line_wdata constant 6 cycles; fill_done 1 cycle after line_ready rises.
- Reset in FILL after 3 beats -> all outputs at reset values next cycle; a following clean fill produces a correct line. Beat injected in DONE -> overrun = 1 and remains set.
- READ_LINE_ASM_CWF_EN with req_word_off = 5 -> fwd_valid exactly once, the cycle after beat 5; fwd_rdata = beat-5 data.
